// File: rtl/ghost_collision_ctrl.sv
// rtl/ghost_collision_ctrl.sv - player/ghost overlap detection and life/death sequencing
// Compares player against every ghost, then drives freeze/respawn/game-over and eaten pulses.
module ghost_collision_ctrl #(
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int NUM_GHOSTS    = 4,
    parameter int HIT_DIST      = 16,
    parameter int LIVES_INIT    = 3,
    parameter int FREEZE_FRAMES = 120
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic                       enable,
    input  logic                       frightened,
    input  logic [X_W-1:0]             player_x,
    input  logic [Y_W-1:0]             player_y,
    input  logic [NUM_GHOSTS*X_W-1:0]  ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]  ghost_y,
    output logic [2:0]                 lives,
    output logic                       freeze,
    output logic                       respawn,
    output logic                       game_over,
    output logic [NUM_GHOSTS-1:0]      ghost_eaten
);

    localparam int              CNT_W = $clog2(FREEZE_FRAMES + 1);
    localparam logic [X_W-1:0]  HIT_X = X_W'(HIT_DIST);
    localparam logic [Y_W-1:0]  HIT_Y = Y_W'(HIT_DIST);
    localparam logic [CNT_W-1:0] FRZ  = CNT_W'(FREEZE_FRAMES);

    typedef enum logic [1:0] {
        S_PLAY    = 2'd0,
        S_DYING   = 2'd1,
        S_RESPAWN = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [2:0]             lives_q;
    logic                   freeze_q;
    logic                   respawn_q;
    logic                   game_over_q;
    logic [NUM_GHOSTS-1:0]  ghost_eaten_q;
    logic [NUM_GHOSTS-1:0]  hit_q;
    logic [NUM_GHOSTS-1:0]  hit_d;
    logic [NUM_GHOSTS-1:0]  hit_prev_q;
    logic [NUM_GHOSTS-1:0]  raw_hit;
    logic [CNT_W-1:0]       cnt_q;

    // Larger-minus-smaller keeps the distance unsigned with no wraparound at screen edges.
    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_dist
        logic [X_W-1:0] gx;
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] gy;
        logic [Y_W-1:0] dy;
        assign gx = ghost_x[g*X_W +: X_W];
        assign gy = ghost_y[g*Y_W +: Y_W];
        assign dx = (gx >= player_x) ? (gx - player_x) : (player_x - gx);
        assign dy = (gy >= player_y) ? (gy - player_y) : (player_y - gy);
        assign raw_hit[g] = (dx < HIT_X) && (dy < HIT_Y);
    end

    always_comb begin
        hit_d = '0;
        if (state_q == S_PLAY && enable) begin
            hit_d = raw_hit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_PLAY;
            lives_q       <= 3'(LIVES_INIT);
            freeze_q      <= 1'b0;
            respawn_q     <= 1'b0;
            game_over_q   <= 1'b0;
            ghost_eaten_q <= '0;
            hit_q         <= '0;
            hit_prev_q    <= '0;
            cnt_q         <= '0;
        end else begin
            hit_q         <= hit_d;
            ghost_eaten_q <= '0;
            respawn_q     <= 1'b0;
            case (state_q)
                S_PLAY: begin
                    hit_prev_q <= hit_q;
                    if (enable && (|hit_q)) begin
                        if (frightened) begin
                            ghost_eaten_q <= hit_q & ~hit_prev_q;
                        end else if (lives_q == 3'd1) begin
                            lives_q     <= 3'd0;
                            game_over_q <= 1'b1;
                            freeze_q    <= 1'b1;
                            state_q     <= S_OVER;
                        end else begin
                            lives_q  <= lives_q - 3'd1;
                            cnt_q    <= FRZ;
                            freeze_q <= 1'b1;
                            state_q  <= S_DYING;
                        end
                    end
                end
                S_DYING: begin
                    hit_prev_q <= '0;
                    freeze_q   <= 1'b1;
                    if (frame_tick) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            respawn_q <= 1'b1;
                            state_q   <= S_RESPAWN;
                        end
                    end
                end
                S_RESPAWN: begin
                    hit_prev_q <= '0;
                    freeze_q   <= 1'b0;
                    state_q    <= S_PLAY;
                end
                S_OVER: begin
                    hit_prev_q  <= '0;
                    lives_q     <= 3'd0;
                    freeze_q    <= 1'b1;
                    game_over_q <= 1'b1;
                end
                default: state_q <= S_PLAY;
            endcase
        end
    end

    assign lives       = lives_q;
    assign freeze      = freeze_q;
    assign respawn     = respawn_q;
    assign game_over   = game_over_q;
    assign ghost_eaten = ghost_eaten_q;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// tb/tb_ghost_collision_ctrl.sv - directed vector bench for ghost_collision_ctrl
module tb_ghost_collision_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b1;
    logic        frightened = 1'b0;
    logic [9:0]  player_x = 10'd100;
    logic [8:0]  player_y = 9'd100;
    logic [39:0] ghost_x;
    logic [35:0] ghost_y;
    logic [2:0]  lives;
    logic        freeze;
    logic        respawn;
    logic        game_over;
    logic [3:0]  ghost_eaten;

    int n_pass = 0;
    int n_total = 0;

    ghost_collision_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (enable),
        .frightened (frightened),
        .player_x   (player_x),
        .player_y   (player_y),
        .ghost_x    (ghost_x),
        .ghost_y    (ghost_y),
        .lives      (lives),
        .freeze     (freeze),
        .respawn    (respawn),
        .game_over  (game_over),
        .ghost_eaten(ghost_eaten)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gidx;
        int px;
        int py;
        int gx;
        int gy;
        bit exp_hit;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        ghost_x[i*10 +: 10] = 10'(x);
        ghost_y[i*9 +: 9]   = 9'(y);
    endtask

    task automatic all_far();
        for (int i = 0; i < 4; i++) set_ghost(i, 600, 400);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Ghost 0 overlaps for two edges, then leaves; returns after the death edge.
    task automatic kill(input int exp_lives);
        set_ghost(0, 110, 108);
        tick();
        tick();
        chk("death_lives", lives, exp_lives);
        chk("death_freeze", freeze, 1);
        all_far();
    endtask

    // Runs a full freeze and checks the single-cycle respawn pulse.
    task automatic full_freeze(input bit overlap_in_respawn);
        frames(119);
        chk("pre_respawn", respawn, 0);
        if (overlap_in_respawn) set_ghost(0, 100, 100);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("respawn_hi", respawn, 1);
        chk("respawn_freeze", freeze, 1);
        tick();
        all_far();
        chk("respawn_lo", respawn, 0);
        chk("unfreeze", freeze, 0);
    endtask

    initial begin
        int pulses;
        int other;
        int bad;
        int resp_cnt;
        int lives_before;

        vecs[0]  = '{0, 100, 100, 116, 100, 1'b0};
        vecs[1]  = '{0, 100, 100, 115, 100, 1'b1};
        vecs[2]  = '{1, 100, 100,  84, 100, 1'b0};
        vecs[3]  = '{1, 100, 100,  85, 100, 1'b1};
        vecs[4]  = '{2, 100, 100, 100, 116, 1'b0};
        vecs[5]  = '{2, 100, 100, 100, 115, 1'b1};
        vecs[6]  = '{3, 100, 100, 100,  84, 1'b0};
        vecs[7]  = '{3, 100, 100, 100,  85, 1'b1};
        vecs[8]  = '{0, 100, 100, 110, 108, 1'b1};
        vecs[9]  = '{1, 100, 100, 115, 115, 1'b1};
        vecs[10] = '{2, 100, 100, 115, 116, 1'b0};
        vecs[11] = '{3,   0,   0,  15,   0, 1'b1};
        vecs[12] = '{0,   0,   0, 639, 479, 1'b0};
        vecs[13] = '{1, 639, 479, 624, 464, 1'b1};

        all_far();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_lives", lives, 3);
        chk("rst_freeze", freeze, 0);
        chk("rst_respawn", respawn, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_eaten", ghost_eaten, 0);

        // Distance boundaries observed through eaten pulses so no lives are lost.
        frightened = 1'b1;
        foreach (vecs[k]) begin
            player_x = 10'(vecs[k].px);
            player_y = 9'(vecs[k].py);
            set_ghost(vecs[k].gidx, vecs[k].gx, vecs[k].gy);
            tick();
            tick();
            chk($sformatf("vec%0d_eaten", k), ghost_eaten,
                vecs[k].exp_hit ? (1 << vecs[k].gidx) : 0);
            all_far();
            repeat (3) tick();
        end
        chk("vec_lives", lives, 3);
        player_x = 10'd100;
        player_y = 9'd100;

        // Ghosts 1 and 3 held in overlap: exactly one joint pulse.
        set_ghost(1, 105, 105);
        set_ghost(3, 95, 95);
        pulses = 0;
        other = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (ghost_eaten == 4'b1010) pulses++;
            else if (ghost_eaten != 4'b0000) other++;
        end
        chk("eaten_once", pulses, 1);
        chk("eaten_other", other, 0);
        chk("eaten_lives", lives, 3);
        all_far();
        repeat (3) tick();
        set_ghost(1, 105, 105);
        set_ghost(3, 95, 95);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ghost_eaten == 4'b1010) pulses++;
        end
        chk("eaten_again", pulses, 1);
        all_far();
        repeat (3) tick();
        frightened = 1'b0;

        // Paused detection ignores overlap.
        enable = 1'b0;
        set_ghost(0, 100, 100);
        repeat (10) tick();
        chk("dis_lives", lives, 3);
        chk("dis_freeze", freeze, 0);
        all_far();
        repeat (2) tick();
        enable = 1'b1;

        // Death 1 with overlap held through the respawn cycle.
        kill(2);
        full_freeze(1'b1);
        repeat (5) tick();
        chk("no_stale_death", lives, 2);
        chk("no_stale_freeze", freeze, 0);

        // Death 2, then death 3 ends the game.
        kill(1);
        full_freeze(1'b0);
        kill(0);
        chk("over_flag", game_over, 1);
        bad = 0;
        resp_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            frame_tick = c[0];
            frightened = c[3];
            if (c[2]) set_ghost(0, 100, 100);
            else all_far();
            tick();
            if (respawn) resp_cnt++;
            if (lives != 3'd0 || !game_over || !freeze || ghost_eaten != 4'b0000) bad++;
        end
        frame_tick = 1'b0;
        frightened = 1'b0;
        all_far();
        chk("over_no_respawn", resp_cnt, 0);
        chk("over_hold", bad, 0);

        // Asynchronous reset from OVER.
        #2 reset = 1'b1;
        #1;
        chk("arst_over_lives", lives, 3);
        chk("arst_over_go", game_over, 0);
        tick();
        reset = 1'b0;
        tick();

        // Asynchronous reset mid-freeze at counter 50.
        kill(2);
        frames(70);
        chk("mid_freeze", freeze, 1);
        lives_before = lives;
        chk("mid_lives", lives_before, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_dying_lives", lives, 3);
        chk("arst_dying_freeze", freeze, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_freeze", freeze, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
